route_demux_16bit: RTL
======================

ROUTE_DEMUX_16BIT -- requirements
Module: route_demux_16bit

Interface
REQ-001 Parameter WIDTH, default 16, data word width.
REQ-002 Parameter CNTW, default 8, width of per-channel transfer counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  word to be routed.
REQ-006 in_sel  input  1  destination: 0 = channel A, 1 = channel B.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 a_data, b_data  output  WIDTH each  buffered word for channel A / B.
REQ-010 a_valid, b_valid  output  1 each  channel buffer holds a word.
REQ-011 a_ready, b_ready  input  1 each  downstream consumes the channel word this cycle.
REQ-012 a_count, b_count  output  CNTW each  words accepted into channel A / B since reset.
REQ-013 busy  output  1  a_valid OR b_valid.

Function
REQ-014 Each channel SHALL hold a one-entry buffer (data register plus valid flag).
REQ-015 in_ready SHALL be combinational: for in_sel=0, (NOT a_valid) OR a_ready; for in_sel=1, (NOT b_valid) OR b_ready.
REQ-016 Input transfer SHALL occur on a rising edge where in_valid AND in_ready are high; there is no transfer otherwise.
REQ-017 On transfer, in_data SHALL load into the selected channel buffer and that channel's valid SHALL be 1 from the following cycle (latency 1 cycle).
REQ-018 Output handshake: a channel word is consumed on an edge where valid AND ready are both high.
REQ-019 Consume without a same-cycle load: channel valid SHALL clear on that edge.
REQ-020 Simultaneous consume and load on the same channel: buffer SHALL take the new word and valid SHALL stay 1, giving full throughput of one word per cycle.
REQ-021 While valid=1 and ready=0, channel data and valid SHALL hold stable; in_valid/in_sel/in_data changes SHALL have no effect on that channel.
REQ-022 The non-selected channel SHALL be unaffected by an input transfer; it SHALL still drain independently on its own handshake.
REQ-023 A blocked channel (full, ready=0) SHALL NOT block a transfer addressed to the other channel.
REQ-024 The selected channel count SHALL increment by 1 on each input transfer; counts are modulo 2^CNTW (all-ones wraps to 0).
REQ-025 a_data/b_data SHALL be driven only from the buffer registers; they do not depend combinationally on in_data.
REQ-026 Outputs with valid=0 carry don't-care data; the bench SHALL NOT check them.

Reset
REQ-027 reset high SHALL immediately, without waiting for clk, clear a_valid, b_valid, busy, a_data, b_data, a_count and b_count to 0.
REQ-028 Buffered words present at reset assertion SHALL be discarded; no transfer or consume SHALL occur on any edge while reset is high.
REQ-029 in_ready during reset SHALL evaluate per REQ-015 using the cleared valids (i.e. 1); transfers are ignored until reset deasserts.

Verification
REQ-030 Scenario: in_sel=0, in_data=16'hA5A5, in_valid one cycle, a_ready=0 -> next cycle a_valid=1, a_data=16'hA5A5, a_count=1, b_valid=0, busy=1.
REQ-031 Scenario: A full, a_ready=0, present in_sel=0 word 16'h1234 -> in_ready=0, A holds 16'hA5A5, a_count unchanged; then in_sel=1 word 16'h1234 -> in_ready=1, next cycle b_data=16'h1234.
REQ-032 Scenario: a_ready=1 continuously, in_sel=0, words 1,2,3,4 on consecutive cycles -> in_ready stays 1, a_data shows 1,2,3,4 on consecutive cycles, a_count=4.
REQ-033 Scenario: 256 transfers to channel B with CNTW=8 -> b_count reads 0 after the 256th, 255 after the 255th.
REQ-034 Scenario: both channels full, assert reset mid-cycle -> a_valid, b_valid, busy, counts go 0 before next clk edge; after release, first word routes normally.

Source files
------------

// File: rtl/route_demux_16bit.sv
// Two-way word router: each input word goes to one of two one-entry channel
// buffers chosen by in_sel, with ready/valid handshakes and per-channel transfer counters.

module route_demux_16bit_chan #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNTW-1:0]  count_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNTW-1:0]  count_q, count_d;

    // A load is only granted when the slot is empty or draining this cycle,
    // so a load always wins over the consume and valid stays high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            count_d = count_q + CNTW'(1);
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign count_o = count_q;
endmodule

module route_demux_16bit #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [WIDTH-1:0] b_data,
    output logic             a_valid,
    output logic             b_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    output logic [CNTW-1:0]  a_count,
    output logic [CNTW-1:0]  b_count,
    output logic             busy
);
    localparam int NCH = 2;

    logic [NCH-1:0]            ch_valid, ch_ready, ch_load;
    logic [NCH-1:0][WIDTH-1:0] ch_data;
    logic [NCH-1:0][CNTW-1:0]  ch_count;
    logic                      xfer;

    assign ch_ready = {b_ready, a_ready};
    // Readiness looks only at the addressed channel, so a stalled channel
    // never blocks traffic headed for the other one.
    assign in_ready = ~ch_valid[in_sel] | ch_ready[in_sel];
    assign xfer     = in_valid & in_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign ch_load[g] = xfer && (in_sel == 1'(g));

        route_demux_16bit_chan #(.WIDTH(WIDTH), .CNTW(CNTW)) u_chan (
            .clk    (clk),
            .reset  (reset),
            .load_i (ch_load[g]),
            .data_i (in_data),
            .ready_i(ch_ready[g]),
            .data_o (ch_data[g]),
            .valid_o(ch_valid[g]),
            .count_o(ch_count[g])
        );
    end

    assign a_data  = ch_data[0];
    assign b_data  = ch_data[1];
    assign a_valid = ch_valid[0];
    assign b_valid = ch_valid[1];
    assign a_count = ch_count[0];
    assign b_count = ch_count[1];
    assign busy    = |ch_valid;
endmodule
